rx_block_sync: RTL and testbench

Clause 49 66-bit block-lock stage for the 10G receive path. Sits between the receive gearbox and the 64b/66b decoder/descrambler that feeds `rx_mac`. It checks each 2-bit sync header and requests bit slips from the gearbox until block alignment holds. It asserts `out_block_lock` and passes aligned blocks downstream only while lock is held.

---
 rtl/rx_block_sync.sv | 147 ++++++++++++++
 tb/tb_rx_block_sync.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_block_sync.sv
// rx_block_sync: 66-bit block-lock stage for the 10G receive path.
// Checks each sync header, requests single-bit slips from the gearbox until
// alignment holds, and forwards aligned blocks only while lock is held.
module rx_block_sync #(
  parameter int LOCK_CNT    = 64,
  parameter int INVALID_MAX = 16,
  parameter int SLIP_WAIT   = 4
) (
  input  logic        rx_clk,
  input  logic        rx_rst,
  input  logic [1:0]  in_pcs_header,
  input  logic [63:0] in_pcs_data,
  input  logic        in_pcs_valid,
  output logic        out_slip,
  output logic        out_block_lock,
  output logic [1:0]  out_pcs_header,
  output logic [63:0] out_pcs_data,
  output logic        out_pcs_valid,
  output logic [15:0] out_slip_count
);

  localparam int WAIT_W = (SLIP_WAIT < 2) ? 1 : $clog2(SLIP_WAIT + 1);
  localparam logic [6:0]        LOCK_CNT_V    = 7'(LOCK_CNT);
  localparam logic [4:0]        INVALID_MAX_V = 5'(INVALID_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LOAD     = WAIT_W'(SLIP_WAIT);

  typedef enum logic [1:0] {
    LOCK_INIT = 2'd0,
    TEST      = 2'd1,
    SLIP_WAIT_ST = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [6:0]         sh_cnt_q, sh_cnt_d;
  logic [4:0]         sh_invalid_cnt_q, sh_invalid_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               lock_q, lock_d;
  logic               slip_q, slip_d;
  logic [15:0]        slip_count_q, slip_count_d;
  logic [1:0]         pcs_header_q, pcs_header_d;
  logic [63:0]        pcs_data_q, pcs_data_d;
  logic               pcs_valid_q, pcs_valid_d;

  logic               hdr_bad;
  logic [6:0]         sh_cnt_inc;
  logic [4:0]         sh_invalid_inc;

  // Slip counter saturates rather than wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Only 2'b01 and 2'b10 are legal sync headers.
  assign hdr_bad = ~(in_pcs_header[1] ^ in_pcs_header[0]);

  // Next-state: lock FSM, window counters and one-cycle datapath register.
  always_comb begin
    state_d          = state_q;
    sh_cnt_d         = sh_cnt_q;
    sh_invalid_cnt_d = sh_invalid_cnt_q;
    wait_cnt_d       = wait_cnt_q;
    lock_d           = lock_q;
    slip_d           = 1'b0;
    slip_count_d     = slip_count_q;
    pcs_header_d     = in_pcs_header;
    pcs_data_d       = in_pcs_data;
    // Forward using the lock value before this edge's update.
    pcs_valid_d      = in_pcs_valid & lock_q;
    sh_cnt_inc       = sh_cnt_q + 7'd1;
    sh_invalid_inc   = sh_invalid_cnt_q + {4'd0, hdr_bad};

    case (state_q)
      LOCK_INIT: begin
        lock_d           = 1'b0;
        sh_cnt_d         = '0;
        sh_invalid_cnt_d = '0;
        wait_cnt_d       = '0;
        state_d          = TEST;
      end
      TEST: begin
        if (in_pcs_valid) begin
          sh_cnt_d         = sh_cnt_inc;
          sh_invalid_cnt_d = sh_invalid_inc;
          // Slip takes precedence over a window that completes on this beat.
          if (hdr_bad && ((sh_invalid_inc == INVALID_MAX_V) || !lock_q)) begin
            lock_d           = 1'b0;
            slip_d           = 1'b1;
            slip_count_d     = sat_inc16(slip_count_q);
            sh_cnt_d         = '0;
            sh_invalid_cnt_d = '0;
            wait_cnt_d       = WAIT_LOAD;
            state_d          = SLIP_WAIT_ST;
          end else if (sh_cnt_inc == LOCK_CNT_V) begin
            if (sh_invalid_inc == 5'd0) lock_d = 1'b1;
            sh_cnt_d         = '0;
            sh_invalid_cnt_d = '0;
          end
        end
      end
      SLIP_WAIT_ST: begin
        // Give the gearbox time to realign; these beats are not evaluated.
        if (in_pcs_valid) begin
          wait_cnt_d = wait_cnt_q - 1'b1;
          if (wait_cnt_d == '0) state_d = TEST;
        end
      end
      default: begin
        state_d = LOCK_INIT;
      end
    endcase
  end

  // State and output registers; reset aborts everything immediately.
  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      state_q          <= LOCK_INIT;
      sh_cnt_q         <= '0;
      sh_invalid_cnt_q <= '0;
      wait_cnt_q       <= '0;
      lock_q           <= 1'b0;
      slip_q           <= 1'b0;
      slip_count_q     <= '0;
      pcs_header_q     <= '0;
      pcs_data_q       <= '0;
      pcs_valid_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      sh_cnt_q         <= sh_cnt_d;
      sh_invalid_cnt_q <= sh_invalid_cnt_d;
      wait_cnt_q       <= wait_cnt_d;
      lock_q           <= lock_d;
      slip_q           <= slip_d;
      slip_count_q     <= slip_count_d;
      pcs_header_q     <= pcs_header_d;
      pcs_data_q       <= pcs_data_d;
      pcs_valid_q      <= pcs_valid_d;
    end
  end

  assign out_slip       = slip_q;
  assign out_block_lock = lock_q;
  assign out_pcs_header = pcs_header_q;
  assign out_pcs_data   = pcs_data_q;
  assign out_pcs_valid  = pcs_valid_q;
  assign out_slip_count = slip_count_q;

endmodule

// File: tb/tb_rx_block_sync.sv
// tb_rx_block_sync: randomized bench for rx_block_sync against a beat-level
// reference model of the block-lock rules.
module tb_rx_block_sync;

  localparam int LOCK_CNT    = 64;
  localparam int INVALID_MAX = 16;
  localparam int SLIP_WAIT   = 4;

  logic        rx_clk;
  logic        rx_rst;
  logic [1:0]  in_pcs_header;
  logic [63:0] in_pcs_data;
  logic        in_pcs_valid;
  logic        out_slip;
  logic        out_block_lock;
  logic [1:0]  out_pcs_header;
  logic [63:0] out_pcs_data;
  logic        out_pcs_valid;
  logic [15:0] out_slip_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit          m_init;
  int          m_wait;
  int          m_n;
  int          m_bad;
  bit          m_lock;
  int          m_slips;
  bit          exp_slip;
  bit          exp_valid;
  logic [1:0]  exp_hdr;
  logic [63:0] exp_data;

  rx_block_sync #(
    .LOCK_CNT(LOCK_CNT), .INVALID_MAX(INVALID_MAX), .SLIP_WAIT(SLIP_WAIT)
  ) dut (
    .rx_clk         (rx_clk),
    .rx_rst         (rx_rst),
    .in_pcs_header  (in_pcs_header),
    .in_pcs_data    (in_pcs_data),
    .in_pcs_valid   (in_pcs_valid),
    .out_slip       (out_slip),
    .out_block_lock (out_block_lock),
    .out_pcs_header (out_pcs_header),
    .out_pcs_data   (out_pcs_data),
    .out_pcs_valid  (out_pcs_valid),
    .out_slip_count (out_slip_count)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
  endfunction

  // One clock edge of the rules: beats after init, minus ignored beats after
  // a slip, accumulate into a window of LOCK_CNT headers.
  task automatic model_step(input bit v, input logic [1:0] h, input logic [63:0] d);
    bit bad;
    exp_valid = v & m_lock;
    exp_hdr   = h;
    exp_data  = d;
    exp_slip  = 1'b0;
    if (m_init) begin
      m_init = 1'b0;
    end else if (v) begin
      if (m_wait > 0) begin
        m_wait--;
      end else begin
        bad = (h == 2'b00) || (h == 2'b11);
        m_n++;
        if (bad) m_bad++;
        if (bad && (m_bad >= INVALID_MAX || !m_lock)) begin
          exp_slip = 1'b1;
          m_lock   = 1'b0;
          if (m_slips < 65535) m_slips++;
          m_n      = 0;
          m_bad    = 0;
          m_wait   = SLIP_WAIT;
        end else if (m_n == LOCK_CNT) begin
          if (m_bad == 0) m_lock = 1'b1;
          m_n   = 0;
          m_bad = 0;
        end
      end
    end
  endtask

  task automatic drive(input bit v, input logic [1:0] h);
    logic [63:0] d;
    d = {$urandom, $urandom};
    in_pcs_valid  = v;
    in_pcs_header = h;
    in_pcs_data   = d;
    @(posedge rx_clk);
    model_step(v, h, d);
    #1;
    check("slip", out_slip, exp_slip);
    check("lock", out_block_lock, m_lock);
    check("valid", out_pcs_valid, exp_valid);
    check("slip_count", out_slip_count, m_slips);
    if (exp_valid) begin
      check("header", out_pcs_header, exp_hdr);
      check("data", out_pcs_data, exp_data);
    end
  endtask

  task automatic apply_reset();
    #3;
    rx_rst       = 1'b0;
    in_pcs_valid = 1'b0;
    #1;
    check("rst_slip", out_slip, 0);
    check("rst_lock", out_block_lock, 0);
    check("rst_valid", out_pcs_valid, 0);
    check("rst_header", out_pcs_header, 0);
    check("rst_data", out_pcs_data, 0);
    check("rst_slip_count", out_slip_count, 0);
    repeat (2) @(posedge rx_clk);
    #2;
    rx_rst  = 1'b1;
    m_init  = 1'b1;
    m_wait  = 0;
    m_n     = 0;
    m_bad   = 0;
    m_lock  = 1'b0;
    m_slips = 0;
    // Edge that leaves the init state; the beat here is not evaluated.
    @(posedge rx_clk);
    model_step(1'b0, 2'b00, 64'd0);
    #1;
    check("init_lock", out_block_lock, m_lock);
  endtask

  task automatic good_beats(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, good_hdr());
  endtask

  task automatic window(input int nbad, input bit last_bad);
    bit flags [LOCK_CNT];
    int k;
    int idx;
    for (int i = 0; i < LOCK_CNT; i++) flags[i] = 1'b0;
    k = 0;
    if (last_bad) begin
      flags[LOCK_CNT-1] = 1'b1;
      k = 1;
    end
    while (k < nbad) begin
      idx = $urandom_range(0, last_bad ? LOCK_CNT - 2 : LOCK_CNT - 1);
      if (!flags[idx]) begin
        flags[idx] = 1'b1;
        k++;
      end
    end
    for (int i = 0; i < LOCK_CNT; i++) drive(1'b1, flags[i] ? bad_hdr() : good_hdr());
  endtask

  initial begin
    rx_rst        = 1'b0;
    in_pcs_valid  = 1'b0;
    in_pcs_header = 2'b00;
    in_pcs_data   = 64'd0;
    @(posedge rx_clk);
    #1;

    // Clean lock
    apply_reset();
    good_beats(63);
    check("no_lock_at_63", out_block_lock, 0);
    good_beats(1);
    check("lock_at_64", out_block_lock, 1);
    good_beats(1);
    check("beat65_valid", out_pcs_valid, 1);
    check("clean_no_slip", out_slip_count, 0);

    // Unlocked slip
    apply_reset();
    good_beats(4);
    drive(1'b1, 2'b11);
    check("unlocked_slip", out_slip, 1);
    check("unlocked_slip_count", out_slip_count, 1);
    good_beats(SLIP_WAIT);
    drive(1'b1, 2'b00);
    check("first_eval_after_wait", out_slip_count, 2);
    good_beats(SLIP_WAIT + LOCK_CNT);
    check("relock_after_slip", out_block_lock, 1);

    // Locked tolerance
    apply_reset();
    good_beats(LOCK_CNT);
    window(INVALID_MAX - 1, 1'b0);
    check("tolerate_15_lock", out_block_lock, 1);
    check("tolerate_15_no_slip", out_slip_count, 0);
    window(INVALID_MAX, 1'b0);
    check("loss_16_lock", out_block_lock, 0);
    check("loss_16_slip", out_slip_count, 1);

    // Gapped input
    apply_reset();
    for (int i = 0; i < LOCK_CNT; i++) begin
      drive(1'b1, good_hdr());
      drive(1'b0, $urandom_range(0, 3));
    end
    check("gapped_lock", out_block_lock, 1);

    // Simultaneous window end and invalid limit
    apply_reset();
    good_beats(LOCK_CNT);
    window(INVALID_MAX, 1'b1);
    check("simul_slip", out_slip, 1);
    check("simul_lock", out_block_lock, 0);

    // Reset mid-window
    apply_reset();
    good_beats(40);
    apply_reset();
    good_beats(LOCK_CNT - 1);
    check("mid_rst_no_lock", out_block_lock, 0);
    good_beats(1);
    check("mid_rst_lock", out_block_lock, 1);

    // Random traffic
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      bit v;
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, (i < 1500) ? 150 : 12) == 0) drive(v, bad_hdr());
      else drive(v, good_hdr());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
